mant_mul_seq: RTL and testbench
===============================

# mant_mul_seq

Multi-cycle mantissa multiply sequencer for the floating-point multiplier. It time-multiplexes one v16x16 multiplier over all 16-bit limb pairs of two wide operands and accumulates the shifted partial products into a full-width product. It sits between the exponent/sign front end and the normalise/round stage, with a valid/ready handshake on both sides. One multiplier instance replaces the 16-instance combinational array, at the cost of NLIMB² cycles per operation.

## Interface
- NLIMB, 4: operand limbs of 16 bits; operand width W = 16·NLIMB; legal values 2..4.
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operands a, b valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a  in  W  multiplicand, unsigned.
- b  in  W  multiplier, unsigned.
- out_valid  out  1  product p valid.
- out_ready  in  1  downstream accepts p.
- p  out  2W  unsigned product a·b.
- busy  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, MUL, DRAIN (only with MUL_PIPE_EN), DONE.
- IDLE: in_ready=1. On in_valid: latch a and b, clear accumulator, clear i and j, go to MUL.
- MUL: each cycle feed a limb i (a[16i+15:16i]) and b limb j to v16x16. Add the 32-bit result, zero-extended and shifted left by 16·(i+j), into the 2W-bit accumulator. j is the inner counter and i the outer; both count 0..NLIMB-1. After pair (NLIMB-1, NLIMB-1), go to DONE, or to DRAIN if pipelined.
- DRAIN: accumulate the final registered partial product, then go to DONE.
- DONE: out_valid=1 and p = accumulator. On out_ready, go to IDLE.
- Arithmetic: the accumulator is exactly 2W bits and never overflows, since a·b < 2^(2W). No rounding, sticky or normalisation is done here.
- Latency is constant and independent of operand value; zero operands still take the full sequence.
- Inputs a and b are ignored outside the IDLE handshake cycle, and latched operands are immune to input changes.
- p and out_valid are held stable while out_ready=0. out_ready is ignored outside DONE.
- No new operation is accepted in the DONE cycle. in_ready rises the cycle after the DONE handshake, which gives one bubble.

## Timing
- Reset values: in_ready=1, out_valid=0, busy=0, p=0, state IDLE, i=j=0.
- rst during any state, including mid-MUL or DONE with a pending product, returns to IDLE next edge. The in-flight product is discarded.
- Handshake edge T (in_valid & in_ready) is followed by NLIMB² MUL cycles. out_valid first appears in cycle T+NLIMB²+1, which is T+17 for NLIMB=4; T+18 with MUL_PIPE_EN.
- Throughput is one product per NLIMB²+2 cycles at best, or NLIMB²+3 pipelined.

## Configuration
- MUL_PIPE_EN defined: a register is placed between the v16x16 output (plus its shift amount) and the accumulator adder. This adds the DRAIN state and one cycle of latency, and shortens the critical path.
- MUL_PIPE_EN undefined: the v16x16 output feeds the accumulator adder in the same cycle, and there is no DRAIN state.

## Structure
- The shared fp-multiplier package holds: LIMB_W=16, the state enum (IDLE, MUL, DRAIN, DONE), and the limb-index counter width function clog2(NLIMB).
- Exactly one sub-module: a single v16x16 instance, unchanged. Limb muxing, shifting, counters and the FSM live in mant_mul_seq.

## Test plan
- a=3, b=5, out_ready=1 -> p=15, out_valid in cycle T+17 (T+18 pipelined), pulse exactly 1 cycle.
- a=b=0xFFFF_FFFF_FFFF_FFFF -> p=0xFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001.
- a=b=0x0000_0001_0000_0000 -> p=0x0000_0000_0000_0001_0000_0000_0000_0000. This checks the limb-pair shift (i=j=2).
- Hold out_ready=0 for 10 cycles in DONE, toggling a, b and in_valid -> p stable, in_ready=0, no new accept. Accept follows one cycle after out_ready.
- Assert rst for 1 cycle at MUL cycle 7 -> next cycle IDLE with all reset values. A following op with a=7, b=9 gives p=63 at the correct latency.
- Back-to-back random ops, 1000 vectors, in_valid held high, random out_ready -> every p equals the reference product, and no op is lost or duplicated.

Source files
------------

// File: rtl/mant_mul_seq_pkg.sv
// Shared fp-multiplier definitions: limb width, sequencer state encoding and
// the limb-index counter width helper.
package mant_mul_seq_pkg;

  localparam int LIMB_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/mant_mul_seq_v16x16.sv
// Plain 16x16 unsigned multiplier shared by every limb pair of the sequencer.
module v16x16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);

  assign p = a * b;

endmodule

// File: rtl/mant_mul_seq.sv
// Multi-cycle mantissa multiplier: walks all limb pairs through one v16x16 and
// accumulates shifted partial products. Define MUL_PIPE_EN to register the
// multiplier output ahead of the accumulator (adds a DRAIN state).
module mant_mul_seq
  import mant_mul_seq_pkg::*;
#(
  parameter int NLIMB = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LIMB_W*NLIMB-1:0]   a,
  input  logic [LIMB_W*NLIMB-1:0]   b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [2*LIMB_W*NLIMB-1:0] p,
  output logic                      busy
);

  localparam int W  = LIMB_W * NLIMB;
  localparam int CW = clog2(NLIMB);
  localparam logic [CW-1:0] LAST = CW'(NLIMB - 1);

  state_e          state_q, state_d;
  logic [W-1:0]    a_q, a_d, b_q, b_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [CW-1:0]   i_q, i_d, j_q, j_d;

  logic [15:0]     limb_a, limb_b;
  logic [31:0]     prod;
  logic [CW:0]     ij;
  logic [2*W-1:0]  pp_sh;

  assign limb_a = a_q[LIMB_W*int'(i_q) +: LIMB_W];
  assign limb_b = b_q[LIMB_W*int'(j_q) +: LIMB_W];
  assign ij     = {1'b0, i_q} + {1'b0, j_q};

  v16x16 u_mul (
    .a (limb_a),
    .b (limb_b),
    .p (prod)
  );

`ifdef MUL_PIPE_EN
  logic [31:0]    prod_q, prod_d;
  logic [CW:0]    ij_q, ij_d;
  logic           pv_q, pv_d;

  // Shift is applied after the pipeline register; {ij, 4'b0} is ij * LIMB_W.
  assign pp_sh = {{(2*W-32){1'b0}}, prod_q} << {ij_q, 4'b0000};
`else
  assign pp_sh = {{(2*W-32){1'b0}}, prod} << {ij, 4'b0000};
`endif

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign out_valid = (state_q == DONE);
  assign p         = acc_q;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    i_d     = i_q;
    j_d     = j_q;
`ifdef MUL_PIPE_EN
    prod_d  = prod_q;
    ij_d    = ij_q;
    pv_d    = pv_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          acc_d   = '0;
          i_d     = '0;
          j_d     = '0;
`ifdef MUL_PIPE_EN
          pv_d    = 1'b0;
`endif
          state_d = MUL;
        end
      end
      MUL: begin
`ifdef MUL_PIPE_EN
        if (pv_q) acc_d = acc_q + pp_sh;
        prod_d = prod;
        ij_d   = ij;
        pv_d   = 1'b1;
`else
        acc_d = acc_q + pp_sh;
`endif
        // j is the inner counter; i advances when j wraps.
        if (j_q == LAST) begin
          j_d = '0;
          if (i_q == LAST) begin
            i_d = '0;
`ifdef MUL_PIPE_EN
            state_d = DRAIN;
`else
            state_d = DONE;
`endif
          end else begin
            i_d = i_q + 1'b1;
          end
        end else begin
          j_d = j_q + 1'b1;
        end
      end
      DRAIN: begin
`ifdef MUL_PIPE_EN
        acc_d = acc_q + pp_sh;
        pv_d  = 1'b0;
`endif
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      j_q     <= '0;
`ifdef MUL_PIPE_EN
      prod_q  <= '0;
      ij_q    <= '0;
      pv_q    <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      j_q     <= j_d;
`ifdef MUL_PIPE_EN
      prod_q  <= prod_d;
      ij_q    <= ij_d;
      pv_q    <= pv_d;
`endif
    end
  end

endmodule

// File: tb/tb_mant_mul_seq.sv
// Directed and back-to-back checks for mant_mul_seq with NLIMB=4 (64-bit
// operands); honours MUL_PIPE_EN for the expected latency.
module tb_mant_mul_seq;

  localparam int NLIMB = 4;
  localparam int W     = 16 * NLIMB;
`ifdef MUL_PIPE_EN
  localparam int EXP_LAT = NLIMB * NLIMB + 2;
`else
  localparam int EXP_LAT = NLIMB * NLIMB + 1;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [W-1:0]   a;
  logic [W-1:0]   b;
  logic           out_valid;
  logic           out_ready;
  logic [2*W-1:0] p;
  logic           busy;

  int checks = 0;
  int errors = 0;

  mant_mul_seq #(.NLIMB(NLIMB)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .p         (p),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  // Starts one operation from a negedge and returns the product together with
  // the number of negedges from the handshake drive to the first out_valid.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        output logic [2*W-1:0] pv, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 200) begin
      @(negedge clk);
      w++;
    end
    a = av;
    b = bv;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    pv = p;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    checks++;
    if (p !== '0) begin errors++; $display("[TB] FAIL reset_p: got %h expected 0", p); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    logic [2*W-1:0] pv;
    int lat;
    out_ready = 1'b1;
    run_op(64'd3, 64'd5, pv, lat);
    checks++;
    if (pv !== 128'd15) begin errors++; $display("[TB] FAIL basic_p: got %h expected %h", pv, 128'd15); end
    checks++;
    if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected %0d", lat, EXP_LAT); end
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("[TB] FAIL basic_pulse: out_valid got %b expected 0", out_valid); end
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL basic_idle: in_ready=%b busy=%b expected 1/0", in_ready, busy);
    end
  endtask

  task automatic test_extremes();
    logic [2*W-1:0] pv;
    int lat;
    out_ready = 1'b1;
    run_op(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, pv, lat);
    checks++;
    if (pv !== 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001) begin
      errors++;
      $display("[TB] FAIL max_p: got %h expected %h", pv, 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001);
    end
    @(negedge clk);
    run_op(64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, pv, lat);
    checks++;
    if (pv !== 128'h0000_0000_0000_0001_0000_0000_0000_0000) begin
      errors++;
      $display("[TB] FAIL shift_p: got %h expected %h", pv, 128'h0000_0000_0000_0001_0000_0000_0000_0000);
    end
    @(negedge clk);
    run_op(64'd0, 64'h1234_5678_9ABC_DEF0, pv, lat);
    checks++;
    if (pv !== '0 || lat !== EXP_LAT) begin
      errors++;
      $display("[TB] FAIL zero_op: got p=%h lat=%0d expected 0 lat=%0d", pv, lat, EXP_LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_hold();
    logic [2*W-1:0] pv;
    int lat;
    int bad;
    out_ready = 1'b0;
    run_op(64'd1000, 64'd1000, pv, lat);
    checks++;
    if (lat !== EXP_LAT) begin errors++; $display("[TB] FAIL hold_latency: got %0d expected %0d", lat, EXP_LAT); end
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      a = {$urandom, $urandom};
      b = {$urandom, $urandom};
      in_valid = k[0];
      @(negedge clk);
      checks++;
      if (p !== 128'd1000000 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++;
        $display("[TB] FAIL hold_stable: got p=%h ov=%b ir=%b expected %h/1/0", p, out_valid, in_ready, 128'd1000000);
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL hold_release: got ir=%b ov=%b expected 1/0", in_ready, out_valid);
    end
  endtask

  task automatic test_reset_mid();
    logic [2*W-1:0] pv;
    int lat;
    out_ready = 1'b1;
    a = 64'hDEAD_BEEF_0123_4567;
    b = 64'hFEDC_BA98_7654_3210;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || p !== '0) begin
      errors++;
      $display("[TB] FAIL midreset_state: got ir=%b busy=%b ov=%b p=%h expected 1/0/0/0", in_ready, busy, out_valid, p);
    end
    run_op(64'd7, 64'd9, pv, lat);
    checks++;
    if (pv !== 128'd63 || lat !== EXP_LAT) begin
      errors++;
      $display("[TB] FAIL midreset_next: got p=%h lat=%0d expected 63 lat=%0d", pv, lat, EXP_LAT);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    logic [2*W-1:0] q[$];
    logic [2*W-1:0] expv;
    int sent, recv, cyc;
    logic pushed;
    sent = 0;
    recv = 0;
    cyc = 0;
    a = {$urandom, $urandom};
    b = {$urandom, $urandom};
    in_valid = 1'b1;
    while (recv < 1000 && cyc < 60000) begin
      out_ready = 1'($urandom_range(0, 1));
      pushed = 1'b0;
      if (out_valid && out_ready) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("[TB] FAIL b2b_extra: got p=%h expected no product", p);
        end else begin
          expv = q.pop_front();
          if (p !== expv) begin
            errors++;
            $display("[TB] FAIL b2b_p: got %h expected %h", p, expv);
          end
        end
        recv++;
      end
      if (in_valid && in_ready) begin
        q.push_back({{W{1'b0}}, a} * {{W{1'b0}}, b});
        sent++;
        pushed = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (pushed) begin
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        if (sent == 1000) in_valid = 1'b0;
      end
    end
    in_valid = 1'b0;
    checks++;
    if (recv !== 1000 || q.size() !== 0) begin
      errors++;
      $display("[TB] FAIL b2b_count: got recv=%0d pending=%0d expected 1000/0", recv, q.size());
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_extremes();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
